store_buffer: RTL and testbench

- Write buffer between `memory_handler`'s memory-side port and the data memory (word-addressed, 4 byte lanes, combinational read data).
- Posts aligned stores into a small FIFO so the pipeline does not wait on a busy memory.
- Drains stores to memory when the port is free.
- Forwards buffered bytes to loads so memory ordering stays sequential as seen by the CPU.

---
 rtl/sb_pkg.sv | 13 +
 rtl/sb_forward_merge.sv | 32 +++
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: the buffered-store entry
// layout and the default geometry.
package sb_pkg;
  localparam int LANES     = 4;
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 10;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [LANES-1:0]     be;
  } sb_entry_t;
endpackage

// File: rtl/sb_forward_merge.sv
// Combinational load forwarding: each byte lane takes the youngest matching
// buffered store that writes that lane, otherwise the memory read data.
module sb_forward_merge
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t             entries [DEPTH],
  input  logic [DEPTH-1:0]      valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [SB_ADDR_W-1:0]  load_addr,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           merged
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from the head (oldest) toward the tail so younger hits overwrite older.
  always_comb begin
    merged = mem_rdata;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (entries[idx].addr == load_addr)) begin
        for (int i = 0; i < LANES; i++) begin
          if (entries[idx].be[i]) merged[8*i +: 8] = entries[idx].data[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-store write buffer between the memory handler and data memory, with
// byte-lane forwarding to loads and a fence that waits for a full drain.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_we,
  input  logic              cpu_fence,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              sb_empty
);
  localparam int PW = $clog2(DEPTH);

  // Handshake: a CPU op is taken on the edge where cpu_valid=1 and cpu_stall=0;
  // a stalled op is held unchanged. A memory access presented on mem_* completes
  // on the edge where mem_ready=1.

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    head, tail, off;
  logic [PW:0]      count;
  logic [DEPTH-1:0] valid;
  logic [31:0]      merged;
  logic             load, store, empty, full, dequeue, enqueue, fence_hold;

  assign load       = cpu_valid && (cpu_we == 4'b0000);
  assign store      = cpu_valid && (cpu_we != 4'b0000);
  assign empty      = (count == '0);
  assign full       = (count == (PW+1)'(DEPTH));
  assign dequeue    = !load && !empty && mem_ready;
  assign fence_hold = cpu_fence && !empty;
  // A store riding along with a held fence is re-presented, so it must not enqueue now.
  assign enqueue    = store && (!full || dequeue) && !fence_hold;

  assign cpu_stall = (load && !mem_ready) || (store && full && !dequeue) || fence_hold;
  assign sb_empty  = empty;
  assign cpu_rdata = load ? merged : 32'h0;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head;
      valid[i] = ({1'b0, off} < count);
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (load) begin
      mem_addr = cpu_addr;
    end else if (!empty) begin
      mem_addr  = entries[head].addr;
      mem_wdata = entries[head].data;
      mem_we    = entries[head].be;
    end
  end

  always_ff @(posedge clk) begin
    if (enqueue) entries[tail] <= '{addr: cpu_addr, data: cpu_wdata, be: cpu_we};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (dequeue) head <= head + PW'(1);
      if (enqueue) tail <= tail + PW'(1);
      case ({enqueue, dequeue})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  sb_forward_merge #(.DEPTH(DEPTH)) u_merge (
    .entries   (entries),
    .valid     (valid),
    .head      (head),
    .load_addr (cpu_addr),
    .mem_rdata (mem_rdata),
    .merged    (merged)
  );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue model of the buffered stores is
// checked against the ports every cycle, plus hand-computed literal checks.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid, cpu_fence, mem_ready;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata, mem_rdata;
  logic [3:0]    cpu_we;
  logic [31:0]   cpu_rdata, mem_wdata;
  logic          cpu_stall, sb_empty;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_fence (cpu_fence),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sb_empty  (sb_empty)
  );

  int total = 0;
  int bad   = 0;

  // Expected buffer contents, oldest first: {addr[45:36], data[35:4], be[3:0]}
  logic [45:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_load();
    return cpu_valid && (cpu_we == 4'b0000);
  endfunction

  function automatic bit m_store();
    return cpu_valid && (cpu_we != 4'b0000);
  endfunction

  function automatic bit m_deq();
    return !m_load() && (exp_q.size() != 0) && mem_ready;
  endfunction

  function automatic bit m_stall();
    return (m_load() && !mem_ready) ||
           (m_store() && (exp_q.size() == DEPTH) && !m_deq()) ||
           (cpu_fence && (exp_q.size() != 0));
  endfunction

  bit m_pop, m_push;
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      m_pop  = m_deq();
      m_push = m_store() && !m_stall();
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({cpu_addr, cpu_wdata, cpu_we});
    end
  end

  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata, e_rdata;
  logic [3:0]    e_we;
  always @(negedge clk) begin
    e_addr  = '0;
    e_wdata = '0;
    e_we    = '0;
    e_rdata = '0;
    if (m_load()) begin
      e_addr  = cpu_addr;
      e_rdata = mem_rdata;
      foreach (exp_q[j]) begin
        if (exp_q[j][45:36] == cpu_addr) begin
          for (int i = 0; i < 4; i++) begin
            if (exp_q[j][i]) e_rdata[8*i +: 8] = exp_q[j][4+8*i +: 8];
          end
        end
      end
    end else if (exp_q.size() != 0) begin
      e_addr  = exp_q[0][45:36];
      e_wdata = exp_q[0][35:4];
      e_we    = exp_q[0][3:0];
    end
    chk("mdl_mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mdl_mem_we", 32'(mem_we), 32'(e_we));
    if (!m_load()) chk("mdl_mem_wdata", mem_wdata, e_wdata);
    if (!m_load() || mem_ready) chk("mdl_cpu_rdata", cpu_rdata, e_rdata);
    chk("mdl_cpu_stall", 32'(cpu_stall), 32'(m_stall()));
    chk("mdl_sb_empty", 32'(sb_empty), 32'(exp_q.size() == 0));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic f, input logic rdy,
                       input logic [31:0] rd);
    cpu_valid = v;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_we    = we;
    cpu_fence = f;
    mem_ready = rdy;
    mem_rdata = rd;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 32'h0, 4'b0000, 1'b0, rdy, 32'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] we);
    drive(1'b1, a, wd, we, 1'b0, 1'b0, 32'h0);
    nxt();
  endtask

  task automatic drain(input string name);
    idle(1'b1);
    for (int i = 0; i < 12; i++) begin
      if (sb_empty === 1'b1) break;
      nxt();
    end
    chk(name, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog at %0t: got timeout want finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1;
    idle(1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    idle(1'b0);
    at_neg();
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    nxt();

    // posted store reaches memory one cycle later
    drive(1'b1, 10'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 32'h0);
    at_neg();
    chk("post_no_write", 32'(mem_we), 32'd0);
    nxt();
    idle(1'b1);
    at_neg();
    chk("post_addr", 32'(mem_addr), 32'd5);
    chk("post_wdata", mem_wdata, 32'hDEADBEEF);
    chk("post_we", 32'(mem_we), 32'hF);
    nxt();
    at_neg();
    chk("post_empty", 32'(sb_empty), 32'd1);
    nxt();

    // fill to full, stall, then enqueue alongside a dequeue
    for (int a = 1; a <= 4; a++) begin
      drive(1'b1, AW'(a), 32'(a) * 32'h01010101, 4'b1111, 1'b0, 1'b0, 32'h0);
      at_neg();
      chk("fill_no_stall", 32'(cpu_stall), 32'd0);
      nxt();
    end
    chk("fill_model_cnt", 32'(exp_q.size()), 32'd4);
    drive(1'b1, 10'd9, 32'h09090909, 4'b1111, 1'b0, 1'b0, 32'h0);
    at_neg();
    chk("full_stall", 32'(cpu_stall), 32'd1);
    nxt();
    drive(1'b1, 10'd9, 32'h09090909, 4'b1111, 1'b0, 1'b1, 32'h0);
    at_neg();
    chk("full_swap_stall", 32'(cpu_stall), 32'd0);
    chk("full_swap_addr", 32'(mem_addr), 32'd1);
    nxt();
    idle(1'b0);
    at_neg();
    chk("full_swap_cnt", 32'(exp_q.size()), 32'd4);
    chk("full_swap_head", 32'(mem_addr), 32'd2);
    nxt();
    drain("drain_full");

    // byte-lane merge of two partial stores
    st(10'd7, 32'hAAAAAAAA, 4'b0001);
    st(10'd7, 32'hBBCCBBCC, 4'b1100);
    drive(1'b1, 10'd7, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h11223344);
    at_neg();
    chk("merge_rdata", cpu_rdata, 32'hBBCC33AA);
    chk("merge_stall", 32'(cpu_stall), 32'd0);
    chk("merge_mem_we", 32'(mem_we), 32'd0);
    nxt();
    idle(1'b0);
    at_neg();
    chk("merge_no_deq", 32'(exp_q.size()), 32'd2);
    nxt();
    drain("drain_merge");

    // youngest of two same-lane stores wins
    st(10'd3, 32'h11111111, 4'b0010);
    st(10'd3, 32'h22222222, 4'b0010);
    drive(1'b1, 10'd3, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    at_neg();
    chk("young_rdata", cpu_rdata, 32'h00002200);
    nxt();
    drain("drain_young");

    // rotate the pointers so the next pair sits across the wrap point
    for (int i = 0; i < 3; i++) st(AW'(10'h40 + i), 32'h0, 4'b1111);
    drain("drain_rot3");
    for (int i = 0; i < 2; i++) st(AW'(10'h50 + i), 32'h0, 4'b1111);
    drain("drain_rot2");
    st(10'd3, 32'h11111111, 4'b0010);
    st(10'd3, 32'h22222222, 4'b0010);
    drive(1'b1, 10'd3, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
    at_neg();
    chk("wrap_rdata", cpu_rdata, 32'h00002200);
    nxt();
    drain("drain_wrap");

    // load waiting on memory holds the buffer
    st(10'h10, 32'hCAFE0010, 4'b1111);
    st(10'h11, 32'hCAFE0011, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 10'h10, 32'h0, 4'b0000, 1'b0, 1'b0, 32'h55555555);
      at_neg();
      chk("ldwait_stall", 32'(cpu_stall), 32'd1);
      chk("ldwait_mem_we", 32'(mem_we), 32'd0);
      nxt();
      chk("ldwait_cnt", 32'(exp_q.size()), 32'd2);
    end
    drive(1'b1, 10'h10, 32'h0, 4'b0000, 1'b0, 1'b1, 32'h55555555);
    at_neg();
    chk("ldwait_done", 32'(cpu_stall), 32'd0);
    chk("ldwait_rdata", cpu_rdata, 32'hCAFE0010);
    nxt();
    drain("drain_ldwait");

    // fence drains two entries
    st(10'h21, 32'h21212121, 4'b1111);
    st(10'h22, 32'h22222222, 4'b1111);
    drive(1'b0, '0, 32'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
    at_neg();
    chk("fence_c1", 32'(cpu_stall), 32'd1);
    nxt();
    at_neg();
    chk("fence_c2", 32'(cpu_stall), 32'd1);
    nxt();
    at_neg();
    chk("fence_c3", 32'(cpu_stall), 32'd0);
    chk("fence_empty", 32'(sb_empty), 32'd1);
    nxt();

    // reset discards buffered entries
    for (int i = 0; i < 3; i++) st(AW'(10'h30 + i), 32'h30303030, 4'b1111);
    rst = 1'b1;
    idle(1'b1);
    nxt();
    rst = 1'b0;
    at_neg();
    chk("rst3_empty", 32'(sb_empty), 32'd1);
    chk("rst3_mem_we", 32'(mem_we), 32'd0);
    chk("rst3_mem_addr", 32'(mem_addr), 32'd0);
    nxt();
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("rst3_no_write", 32'(mem_we), 32'd0);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
